// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and
// registers the fetched instruction into the IF/ID pipeline register.
// Redirects from ID (taken branch or jump) override hazard stalls and
// insert exactly one bubble. Two saturating counters record IF/ID hold
// cycles and redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PC_stall,
    input  logic        IF_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc_plus4,
    output logic        IF_ID_valid,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic [31:0] pc_q,         pc_d;
    logic [31:0] if_instr_q,   if_instr_d;
    logic [31:0] if_pc4_q,     if_pc4_d;
    logic        if_valid_q,   if_valid_d;
    logic [15:0] stall_cnt_q,  stall_cnt_d;
    logic [15:0] flush_cnt_q,  flush_cnt_d;

    logic        redirect;
    logic [31:0] pc_plus4;

    // Next-state logic for the PC, the IF/ID register and both counters.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        pc_d        = pc_q;
        if_instr_d  = if_instr_q;
        if_pc4_d    = if_pc4_q;
        if_valid_d  = if_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        redirect = branch_taken | jump;
        // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 = 32'h0.
        pc_plus4 = pc_q + 32'd4;

        // Branch beats jump when both fire; targets are word-aligned.
        if (branch_taken) begin
            pc_d = {branch_target[31:2], 2'b00};
        end else if (jump) begin
            pc_d = {jump_target[31:2], 2'b00};
        end else if (!PC_stall) begin
            pc_d = pc_plus4;
        end

        // The redirecting instruction is older than whatever is stalled,
        // so a redirect flushes IF/ID even when IF_stall is asserted.
        if (redirect) begin
            if_instr_d = NOP_INSTR;
            if_pc4_d   = 32'h0;
            if_valid_d = 1'b0;
        end else if (!IF_stall) begin
            if_instr_d = imem_instr;
            if_pc4_d   = pc_plus4;
            if_valid_d = 1'b1;
        end

        if (IF_stall && !redirect && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        if (redirect && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // State registers with synchronous active-low reset taking top priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their _d values from before the edge; always_comb above
        // uses blocking assignments because it is evaluated top to bottom.
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            if_instr_q  <= NOP_INSTR;
            if_pc4_q    <= 32'h0;
            if_valid_q  <= 1'b0;
            stall_cnt_q <= 16'h0;
            flush_cnt_q <= 16'h0;
        end else begin
            pc_q        <= pc_d;
            if_instr_q  <= if_instr_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Memory address comes straight from the PC register: no input-to-output path.
    assign imem_addr      = pc_q;
    assign IF_ID_instr    = if_instr_q;
    assign IF_ID_pc_plus4 = if_pc4_q;
    assign IF_ID_valid    = if_valid_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory is modelled as
// imem_instr = 32'h1111_0000 + imem_addr.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        PC_stall;
    logic        IF_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc_plus4;
    logic        IF_ID_valid;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .PC_stall       (PC_stall),
        .IF_stall       (IF_stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_instr     (imem_instr),
        .imem_addr      (imem_addr),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_valid    (IF_ID_valid),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = 32'h1111_0000 + imem_addr;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
        chk({tag, "_instr"}, IF_ID_instr, instr);
        chk({tag, "_pc4"},   IF_ID_pc_plus4, pc4);
        chk({tag, "_valid"}, {31'b0, IF_ID_valid}, {31'b0, valid});
    endtask

    initial begin
        reset_n = 1'b0; PC_stall = 1'b0; IF_stall = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;

        // Reset state.
        step(); step();
        chk("rst_pc", imem_addr, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst_stall", {16'h0, stall_count}, 32'h0);
        chk("rst_flush", {16'h0, flush_count}, 32'h0);

        // Sequential fetch from RESET_PC, one-cycle latency.
        reset_n = 1'b1;
        step();
        chk("seq0_pc", imem_addr, 32'h4);
        chk_ifid("seq0", 32'h1111_0000, 32'h4, 1'b1);
        step();
        chk("seq1_pc", imem_addr, 32'h8);
        chk_ifid("seq1", 32'h1111_0004, 32'h8, 1'b1);
        step(); step();
        chk("seq3_pc", imem_addr, 32'h10);
        chk_ifid("seq3", 32'h1111_000C, 32'h10, 1'b1);

        // Full stall for three cycles at PC 0x10.
        PC_stall = 1'b1; IF_stall = 1'b1;
        step(); step(); step();
        chk("stall_pc", imem_addr, 32'h10);
        chk_ifid("stall", 32'h1111_000C, 32'h10, 1'b1);
        chk("stall_cnt3", {16'h0, stall_count}, 32'd3);

        // PC held, IF/ID reloads from the same address.
        IF_stall = 1'b0;
        step();
        chk("pcst_pc", imem_addr, 32'h10);
        chk_ifid("pcst", 32'h1111_0010, 32'h14, 1'b1);
        chk("pcst_cnt", {16'h0, stall_count}, 32'd3);

        PC_stall = 1'b0;
        step(); step(); step(); step();
        chk("run_pc", imem_addr, 32'h20);
        chk_ifid("run", 32'h1111_001C, 32'h20, 1'b1);

        // Taken branch overrides IF_stall; target bits [1:0] cleared.
        branch_taken = 1'b1; branch_target = 32'h103; IF_stall = 1'b1;
        step();
        chk("br_pc", imem_addr, 32'h100);
        chk_ifid("br_flush", 32'h0, 32'h0, 1'b0);
        chk("br_flushcnt", {16'h0, flush_count}, 32'd1);
        chk("br_stallcnt", {16'h0, stall_count}, 32'd3);
        branch_taken = 1'b0; IF_stall = 1'b0;
        step();
        chk("br_tgt_pc", imem_addr, 32'h104);
        chk_ifid("br_tgt", 32'h1111_0100, 32'h104, 1'b1);

        // Branch and jump together: branch wins.
        branch_taken = 1'b1; branch_target = 32'h200; jump = 1'b1; jump_target = 32'h300;
        step();
        chk("bj_pc", imem_addr, 32'h200);
        chk("bj_flushcnt", {16'h0, flush_count}, 32'd2);

        // Jump alone, misaligned target.
        branch_taken = 1'b0; jump_target = 32'h302;
        step();
        chk("jmp_pc", imem_addr, 32'h300);
        chk_ifid("jmp_flush", 32'h0, 32'h0, 1'b0);
        jump = 1'b0;
        step();
        chk("jmp_tgt_pc", imem_addr, 32'h304);
        chk_ifid("jmp_tgt", 32'h1111_0300, 32'h304, 1'b1);

        // PC wrap at the top of the address space.
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step();
        chk("wrap_pc0", imem_addr, 32'hFFFF_FFFC);
        jump = 1'b0;
        step();
        chk("wrap_pc1", imem_addr, 32'h0);
        chk_ifid("wrap", 32'h1110_FFFC, 32'h0, 1'b1);
        chk("wrap_flushcnt", {16'h0, flush_count}, 32'd4);

        // Redirect beats PC_stall.
        branch_taken = 1'b1; branch_target = 32'h400; PC_stall = 1'b1;
        step();
        chk("brpcst_pc", imem_addr, 32'h400);
        branch_taken = 1'b0;

        // Build stall_count to 5, then reset mid-stall and mid-redirect.
        IF_stall = 1'b1;
        step(); step();
        chk("stall_cnt5", {16'h0, stall_count}, 32'd5);
        chk("stall_held_pc", imem_addr, 32'h400);
        reset_n = 1'b0; branch_taken = 1'b1; branch_target = 32'h500;
        step();
        chk("mrst_pc", imem_addr, 32'h0);
        chk_ifid("mrst", 32'h0, 32'h0, 1'b0);
        chk("mrst_stall", {16'h0, stall_count}, 32'h0);
        chk("mrst_flush", {16'h0, flush_count}, 32'h0);

        // First edge out of reset fetches RESET_PC normally.
        reset_n = 1'b1; branch_taken = 1'b0; PC_stall = 1'b0; IF_stall = 1'b0;
        step();
        chk("rel_pc", imem_addr, 32'h4);
        chk_ifid("rel", 32'h1111_0000, 32'h4, 1'b1);

        // Drive stall_count to saturation and confirm it sticks.
        PC_stall = 1'b1; IF_stall = 1'b1;
        repeat (65535) step();
        chk("sat_reach", {16'h0, stall_count}, 32'h0000_FFFF);
        step();
        chk("sat_hold", {16'h0, stall_count}, 32'h0000_FFFF);
        chk_ifid("sat_ifid", 32'h1111_0000, 32'h4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
